// File: rtl/serial_deshifter.sv
// Deserialiser for the gated 10 MHz Wallops bit stream.
// It samples serial_in on the synchronised falling edge of gclk and delivers one parallel word after every N+1 bits.
module serial_deshifter #(
  parameter int unsigned N   = 9,
  parameter int unsigned GAP = 16
) (
  input  logic         clk50,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         gclk,
  input  logic         serial_in,
  input  logic         data_ack,
  output logic [N:0]   dbus_out,
  output logic         data_valid,
  output logic         overrun,
  output logic         busy,
  output logic [15:0]  word_count
);

  localparam int unsigned CW = $clog2(N + 2);
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [1:0]     r_gclk_sync;
  logic [1:0]     r_sin_sync;
  logic [N-1:0]   r_shift;
  logic [CW-1:0]  r_bit_cnt;
  logic [GW-1:0]  r_gap;
  logic [N:0]     r_dbus;
  logic           r_valid;
  logic           r_overrun;
  logic [15:0]    r_count;

  logic           w_edge;
  logic           w_sample;
  logic [N:0]     w_word;
  logic           w_last;
  logic           w_timeout;
  logic           w_deliver_ok;

  assign w_edge       = (r_gclk_sync == 2'b10);
  assign w_sample     = r_sin_sync[1];
  assign w_word       = {r_shift, w_sample};
  assign w_last       = w_edge && (r_bit_cnt == CW'(N));
  assign w_timeout    = (r_state == SHIFT) && !w_edge && (r_gap == GW'(GAP - 1));
  assign w_deliver_ok = !r_valid || data_ack;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_edge && !w_last)     w_state_next = SHIFT;
        SHIFT:   if (w_last || w_timeout)   w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == SHIFT);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_gclk_sync <= '0;
      r_sin_sync  <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap       <= '0;
      r_dbus      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_count     <= '0;
    end else if (!enable) begin
      r_gclk_sync <= '0;
      r_sin_sync  <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap       <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_gclk_sync <= {r_gclk_sync[0], gclk};
      r_sin_sync  <= {r_sin_sync[0], serial_in};
      // An acknowledge clears valid unless a word lands in the same cycle, which re-asserts it below.
      if (data_ack) r_valid <= 1'b0;
      if (w_edge) begin
        r_gap   <= '0;
        r_shift <= w_word[N-1:0];
        if (w_last) begin
          r_bit_cnt <= '0;
          if (w_deliver_ok) begin
            r_dbus  <= w_word;
            r_valid <= 1'b1;
            r_count <= r_count + 16'd1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end else if (w_timeout) begin
        r_gap     <= '0;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (r_state == SHIFT) begin
        r_gap <= r_gap + GW'(1);
      end
    end
  end

  assign dbus_out   = r_dbus;
  assign data_valid = r_valid;
  assign overrun    = r_overrun;
  assign word_count = r_count;

endmodule

// File: tb/tb_serial_deshifter.sv
// Bench for serial_deshifter.
// A word-level reference model feeds a scoreboard queue, and a monitor checks each delivered word against it.
`timescale 1ns/1ps
module tb_serial_deshifter;

  localparam int unsigned N   = 9;
  localparam int unsigned GAP = 16;

  logic         clk50 = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b1;
  logic         gclk = 1'b0;
  logic         serial_in = 1'b0;
  logic         data_ack = 1'b0;
  logic [N:0]   dbus_out;
  logic         data_valid;
  logic         overrun;
  logic         busy;
  logic [15:0]  word_count;

  serial_deshifter #(.N(N), .GAP(GAP)) dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .enable     (enable),
    .gclk       (gclk),
    .serial_in  (serial_in),
    .data_ack   (data_ack),
    .dbus_out   (dbus_out),
    .data_valid (data_valid),
    .overrun    (overrun),
    .busy       (busy),
    .word_count (word_count)
  );

  always #10 clk50 = ~clk50;

  typedef struct packed {
    logic [N:0]  word;
    logic [15:0] count;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [N:0]  m_dbus;
  logic        m_valid;
  logic        m_overrun;
  logic [15:0] m_count;
  logic [15:0] prev_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic exp_busy);
    check({tag, "_dbus"},    32'(dbus_out),   32'(m_dbus));
    check({tag, "_valid"},   32'(data_valid), 32'(m_valid));
    check({tag, "_overrun"}, 32'(overrun),    32'(m_overrun));
    check({tag, "_busy"},    32'(busy),       32'(exp_busy));
    check({tag, "_count"},   32'(word_count), 32'(m_count));
  endtask

  always @(negedge clk50) begin
    if (rst_n && word_count != prev_count) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_delivery", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_word",  32'(dbus_out),   32'(e.word));
        check("sb_count", 32'(word_count), 32'(e.count));
        check("sb_valid", 32'(data_valid), 32'd1);
      end
    end
    prev_count = word_count;
  end

  // One gclk period: rise, data change shortly after, fall two clk50 cycles later, then low.
  task automatic send_bit(input logic b, input logic ack_here);
    @(negedge clk50);
    gclk = 1'b1;
    #2 serial_in = b;
    @(negedge clk50);
    @(negedge clk50);
    gclk = 1'b0;
    if (ack_here) begin
      @(posedge clk50);
      #1 data_ack = 1'b1;
      @(posedge clk50);
      #1 data_ack = 1'b0;
      @(negedge clk50);
      @(negedge clk50);
    end else begin
      repeat (3) @(negedge clk50);
    end
  endtask

  task automatic send_word(input logic [N:0] w, input logic ack_at_delivery);
    for (int i = N; i >= 0; i--) send_bit(w[i], ack_at_delivery && (i == 0));
  endtask

  task automatic model_word(input logic [N:0] w, input logic acked);
    if (acked || !m_valid) begin
      m_dbus  = w;
      m_valid = 1'b1;
      m_count = m_count + 16'd1;
      sb_q.push_back('{word: w, count: m_count});
    end else begin
      m_overrun = 1'b1;
    end
  endtask

  task automatic word(input logic [N:0] w, input logic ack_at_delivery);
    model_word(w, ack_at_delivery);
    send_word(w, ack_at_delivery);
  endtask

  task automatic ack_pulse();
    @(negedge clk50);
    data_ack = 1'b1;
    @(negedge clk50);
    data_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic enable_pulse();
    @(negedge clk50);
    enable = 1'b0;
    @(negedge clk50);
    enable = 1'b1;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk50);
    #3 rst_n = 1'b0;
    #1;
    m_dbus = '0; m_valid = 1'b0; m_overrun = 1'b0; m_count = '0;
    check_state(tag, 1'b0);
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N:0] w;
    logic       a;

    m_dbus = '0; m_valid = 1'b0; m_overrun = 1'b0; m_count = '0;
    do_reset("reset0");
    repeat (3) @(negedge clk50);
    check_state("post_reset_idle", 1'b0);

    word(10'h2A5, 1'b0);
    check_state("word_2a5", 1'b0);

    do_reset("reset1");
    word(10'h155, 1'b0);
    word(10'h0F0, 1'b0);
    check_state("overrun", 1'b0);

    do_reset("reset2");
    word(10'h155, 1'b0);
    word(10'h0F0, 1'b1);
    check_state("ack_at_delivery", 1'b0);

    do_reset("reset3");
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("gap_busy_after_5", 32'(busy), 32'd1);
    repeat (12) @(negedge clk50);
    check("gap_busy_before_timeout", 32'(busy), 32'd1);
    repeat (8) @(negedge clk50);
    check("gap_busy_after_timeout", 32'(busy), 32'd0);
    word(10'h3FF, 1'b0);
    check_state("gap_then_3ff", 1'b0);

    do_reset("reset4");
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    check("en_busy_mid", 32'(busy), 32'd1);
    enable_pulse();
    check("en_busy_cleared", 32'(busy), 32'd0);
    word(10'h001, 1'b0);
    check_state("en_then_001", 1'b0);

    for (int i = 0; i < 6; i++) send_bit(1'(i % 2), 1'b0);
    do_reset("reset_midword");
    word(10'h200, 1'b0);
    check_state("reset_then_200", 1'b0);

    for (int k = 0; k < 40; k++) begin
      w = N'(0) | (N+1)'($urandom_range(0, 1023));
      a = ($urandom_range(0, 3) == 0);
      word(w, a);
      if ($urandom_range(0, 2) == 0) ack_pulse();
      if ($urandom_range(0, 9) == 0) enable_pulse();
      repeat ($urandom_range(0, 8)) @(negedge clk50);
      check_state("rand", 1'b0);
    end

    repeat (4) @(negedge clk50);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_deshifter.md
SERIAL_DESHIFTER -- requirements
Module: serial_deshifter

Interface
REQ-001 Parameter: N, default 9, MSB index of received word (word width N+1 bits).
REQ-002 Parameter: GAP, default 16, clk50 cycles without a sampling edge before a partial word is discarded.
REQ-003 clk50  input  1  50 MHz system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  receiver enable; low = synchronous clear (REQ-022).
REQ-006 gclk  input  1  10 MHz gated bit clock from Wallops, asynchronous to clk50.
REQ-007 serial_in  input  1  serial data, MSB first; changes after gclk rising edge.
REQ-008 data_ack  input  1  consumer acknowledge; one clk50 pulse clears data_valid.
REQ-009 dbus_out  output  N+1  last complete received word.
REQ-010 data_valid  output  1  dbus_out holds an unacknowledged word.
REQ-011 overrun  output  1  sticky: a word arrived while data_valid=1 and not acked.
REQ-012 busy  output  1  high while a word is partially received (state SHIFT).
REQ-013 word_count  output  16  count of words delivered, wraps 0xFFFF->0x0000.

Function
REQ-014 gclk and serial_in SHALL each pass through a 2-flop synchronizer (gclk_reg[1:0], sin_reg[1:0]), shifting only while enable=1.
REQ-015 A sampling edge SHALL be gclk_reg==2'b10 (synchronized falling edge, mid-bit); sampled value SHALL be sin_reg[1] in that cycle.
REQ-016 On each sampling edge: shift_reg <= {shift_reg[N-1:0], sample}; bit_cnt increments.
REQ-017 States: IDLE (bit_cnt=0) and SHIFT (1<=bit_cnt<=N); IDLE->SHIFT on first sampling edge; SHIFT->IDLE on (N+1)th sampling edge or gap timeout.
REQ-018 On the (N+1)th sampling edge, on that same clk50 edge: dbus_out <= {shift_reg[N-1:0], sample}, data_valid <= 1, word_count += 1, bit_cnt <= 0 (zero extra latency after synchronizer).
REQ-019 Word delivered while data_valid=1 and data_ack=0: dbus_out, data_valid, word_count unchanged; new word dropped; overrun <= 1.
REQ-020 Word delivered in same cycle as data_ack=1: new word loaded, data_valid stays 1, overrun unchanged; data_ack with no delivery clears data_valid; data_ack while data_valid=0 has no effect.
REQ-021 Gap counter SHALL reset on every sampling edge and count in SHIFT; at GAP cycles without an edge, bit_cnt <= 0, state <= IDLE, shift_reg <= 0, nothing delivered, word_count unchanged.
REQ-022 enable=0 SHALL synchronously clear gclk_reg, sin_reg, shift_reg, bit_cnt, gap counter, state (IDLE), data_valid and overrun; dbus_out and word_count SHALL hold.
REQ-023 overrun SHALL clear only by reset or enable=0.
REQ-024 busy SHALL be 1 exactly when state==SHIFT.

Reset
REQ-025 rst_n=0 SHALL immediately force dbus_out=0, data_valid=0, overrun=0, busy=0, word_count=0, and all internal registers to 0/IDLE, regardless of clk50.
REQ-026 Reset mid-word SHALL discard the partial word; first sampling edge after release starts a new word at bit 0.
REQ-027 Outputs SHALL remain at reset values until the first delivered word after rst_n rises.

Verification
REQ-028 10 gclk periods, serial_in MSB-first 10'h2A5 -> dbus_out=0x2A5, data_valid=1, word_count=1, busy=0, overrun=0.
REQ-029 0x155 then 0x0F0 with no data_ack -> dbus_out=0x155, data_valid=1, overrun=1, word_count=1.
REQ-030 0x155, then data_ack pulsed in the exact delivery cycle of 0x0F0 -> dbus_out=0x0F0, data_valid=1, overrun=0, word_count=2.
REQ-031 5 bits of 1, gclk idle 20 clk50 cycles, then 10 bits 0x3FF -> busy drops after 16 idle cycles, single word 0x3FF, word_count=1.
REQ-032 enable=0 for 1 cycle after 4 bits, then full 0x001 -> dbus_out=0x001, word_count=1, overrun=0; rst_n pulse after 6 bits -> all outputs 0, next full 0x200 gives dbus_out=0x200, word_count=1.
